// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one cache-line memory port between the I-side and D-side controllers,
// one transaction outstanding at a time, with optional round-robin and a sticky watchdog.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int LINE_W  = 512,
  parameter int RR      = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_wren,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_reqack,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_reqack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              bus_req,
  output logic              bus_wren,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [LINE_W-1:0] bus_wdata,
  input  logic              bus_reqack,
  input  logic [LINE_W-1:0] bus_rdata,
  input  logic              bus_done,
  output logic              busy,
  output logic              timeout
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d;
  logic              bus_req_q, bus_req_d, bus_wren_q, bus_wren_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [LINE_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_reqack_q, i_reqack_d, d_reqack_q, d_reqack_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d, busy_q;
  logic              grant_d, fin, expired;
  // owner/last encoding: 0 = I-side, 1 = D-side
  assign grant_d = d_req && (!i_req || RR == 0 || !last_q);
  assign fin     = (state_q == ISSUE && bus_reqack && bus_done) || (state_q == WAIT && bus_done);
  assign expired = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT));
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    bus_req_d   = bus_req_q;
    bus_wren_d  = bus_wren_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    i_reqack_d  = 1'b0;
    d_reqack_d  = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (i_req || d_req) begin
        state_d     = ISSUE;
        owner_d     = grant_d;
        last_d      = grant_d;
        bus_req_d   = 1'b1;
        bus_wren_d  = grant_d ? d_wren : i_wren;
        bus_addr_d  = (grant_d ? d_addr : i_addr) & ~{{(ADDR_W-6){1'b0}}, 6'h3f};
        bus_wdata_d = grant_d ? d_wdata : i_wdata;
        i_reqack_d  = !grant_d;
        d_reqack_d  = grant_d;
        cnt_d       = '0;
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (fin || expired) begin
      // completion beats the watchdog when both land in the same cycle
      state_d   = RESP;
      bus_req_d = 1'b0;
      i_done_d  = !owner_q;
      d_done_d  = owner_q;
      if (!fin) begin
        timeout_d = 1'b1;
        d_rdata_d = owner_q ? '0 : d_rdata_q;
        i_rdata_d = owner_q ? i_rdata_q : '0;
      end else if (!bus_wren_q) begin
        d_rdata_d = owner_q ? bus_rdata : d_rdata_q;
        i_rdata_d = owner_q ? i_rdata_q : bus_rdata;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == ISSUE && bus_reqack) begin
        state_d   = WAIT;
        bus_req_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wren_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_reqack_q  <= 1'b0;
      d_reqack_q  <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      bus_req_q   <= bus_req_d;
      bus_wren_q  <= bus_wren_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_reqack_q  <= i_reqack_d;
      d_reqack_q  <= d_reqack_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      busy_q      <= (state_d != IDLE);
    end
  end
  assign i_reqack  = i_reqack_q;
  assign d_reqack  = d_reqack_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_wren  = bus_wren_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
endmodule
